config_chain_master: RTL and testbench
======================================

CONFIG_CHAIN_MASTER -- requirements
Module: config_chain_master

Interface
REQ-001 SHALL have parameter CHAIN_DEPTH, default 3: number of fp::fpType registers in the attached config chain; legal range 1..255.
REQ-002 SHALL have parameter DIV, default 2: clk cycles per data_clk phase (setup, high, low); legal range 1..255.
REQ-003 clk  input  1  single system clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wr_valid  input  1  host offers wr_data.
REQ-006 wr_ready  output  1  block accepts a word this cycle.
REQ-007 wr_data  input  fp::WORD_LENGTH  configuration word to shift into the chain.
REQ-008 cfg_out  config_if.master  --  drives data_clk and data_in into the first chain stage.
REQ-009 cfg_ret  config_if.slave  --  data_in from the last chain stage (readback); its data_clk is ignored.
REQ-010 rd_valid  output  1  one-cycle strobe: rd_data holds a word shifted out of the chain.
REQ-011 rd_data  output  fp::WORD_LENGTH  readback word.
REQ-012 load_done  output  1  one-cycle strobe after every CHAIN_DEPTH-th word completes.
REQ-013 word_cnt  output  8  words completed in the current load pass.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, CLK_HIGH and CLK_LOW, plus a phase counter 0..DIV-1.
REQ-015 wr_ready SHALL be 1 only in IDLE; it is combinational from state.
REQ-016 On an edge with IDLE, wr_valid=1: cfg_out.data_in <= wr_data; go to SETUP; phase <= 0.
REQ-017 A word offered with wr_ready=0 SHALL be ignored; wr_valid SHALL never be latched while busy.
REQ-018 SETUP SHALL last DIV cycles, then go to CLK_HIGH with data_clk <= 1; acceptance edge A gives the rising edge at A+DIV.
REQ-019 CLK_HIGH SHALL last DIV cycles, then go to CLK_LOW with data_clk <= 0 at edge A+2*DIV.
REQ-020 CLK_LOW SHALL last DIV cycles, then go to IDLE at edge A+3*DIV; earliest next acceptance is edge A+3*DIV+1.
REQ-021 cfg_out.data_in SHALL remain stable from acceptance until the next acceptance.
REQ-022 data_clk and data_in SHALL be driven directly from flops: no glitches and no combinational paths from inputs.
REQ-023 At the edge that sets data_clk to 1, rd_data <= cfg_ret.data_in (the pre-shift value) and rd_valid <= 1 for exactly one cycle.
REQ-024 word_cnt SHALL increment at the CLK_LOW->IDLE edge.
REQ-025 At CHAIN_DEPTH-1, that same edge SHALL wrap word_cnt to 0 and pulse load_done for one cycle.
REQ-026 CHAIN_DEPTH=1 SHALL pulse load_done after every word.
REQ-027 Back-to-back wr_valid SHALL sustain exactly one word per 3*DIV+1 cycles.

Reset
REQ-028 Asserting reset (low) at any time SHALL immediately clear the following: state=IDLE, phase=0, data_clk=0, data_in=0, rd_data=0, rd_valid=0, load_done=0, word_cnt=0.
REQ-029 Reset during CLK_HIGH SHALL drop data_clk without producing an extra rising edge.
REQ-030 A word in flight when reset asserts SHALL be discarded; the chain contents are undefined and the host reloads the chain.
REQ-031 Deassertion SHALL take effect at the next clk edge; wr_ready is 1 in the first cycle after deassertion.

Structure
REQ-032 fp::fpType and fp::WORD_LENGTH SHALL come from the shared fp package.
REQ-033 A cfg_state_t enum and a CFG_CNT_WIDTH=8 constant SHALL be added to a shared cfg package, for reuse by the chain-timing checker.
REQ-034 Phase timing SHALL be a sub-module cfg_phase_timer, with load, DIV and expire signals.
REQ-035 All other logic SHALL be in config_chain_master.

Verification
REQ-036 Timing check, DIV=2, wr_data=16'h1234 accepted at edge 10:
- data_in=16'h1234 after edge 10.
- data_clk rises at edge 12 and falls at edge 14.
- wr_ready returns after edge 16.
REQ-037 Readback check, 3-stage chain model with CHAIN_DEPTH=3:
- Load 16'h1111, 16'h2222, 16'h3333, then 16'hAAAA, 16'hBBBB, 16'hCCCC.
- Second-pass rd_data sequence SHALL be 16'h1111, 16'h2222, 16'h3333.
- load_done SHALL pulse twice.
REQ-038 Continuous wr_valid for 6 words, DIV=1: acceptances every 4 cycles, 6 data_clk pulses, word_cnt sequence 1,2,0,1,2,0.
REQ-039 Busy check: wr_valid with 16'hDEAD during CLK_HIGH SHALL not be accepted; data_in keeps the prior word.
REQ-040 Reset mid-CLK_HIGH:
- data_clk=0 within the same cycle, with no further rising edge.
- word_cnt=0 after reset.
- The next load of 3 words gives exactly one load_done.
REQ-041 CHAIN_DEPTH=1: each of 3 words produces load_done, and rd_data returns the previous word.

Source files
------------

// File: rtl/config_chain_master_pkg.sv
// Shared word format (fp) and config-chain sequencing types (cfg) used by the
// chain master and by the chain-timing checker.
package fp;
  localparam int WORD_LENGTH = 16;
  typedef logic [WORD_LENGTH-1:0] fpType;
endpackage

package cfg;
  localparam int CFG_CNT_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    CLK_HIGH = 2'd2,
    CLK_LOW  = 2'd3
  } cfg_state_t;
endpackage

// File: rtl/config_chain_master_if.sv
// Serial config-chain link: one data_clk plus a full-word data bus per stage.
interface config_if;
  logic      data_clk;
  fp::fpType data_in;

  modport master (output data_clk, output data_in);
  modport slave  (input  data_clk, input  data_in);
endinterface

// File: rtl/config_chain_master_phase_timer.sv
// Down-counting phase timer: load restarts a DIV-cycle interval, expire flags
// the last cycle of that interval (terminal count reached).
module cfg_phase_timer
  import cfg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic expire_o
);

  localparam logic [CFG_CNT_WIDTH-1:0] LOAD_VAL = CFG_CNT_WIDTH'(DIV - 1);

  logic [CFG_CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CFG_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/config_chain_master.sv
// Shifts host words into a config register chain, one data_clk pulse per word,
// and returns the word falling out of the last stage as readback.
//
// state    | meaning
// IDLE     | wr_ready high, waiting for a host word
// SETUP    | data_in settling ahead of the rising data_clk
// CLK_HIGH | data_clk high, chain captures data_in
// CLK_LOW  | data_clk low hold before the next word
module config_chain_master
  import fp::*;
  import cfg::*;
#(
  parameter int unsigned CHAIN_DEPTH = 3,
  parameter int unsigned DIV         = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  fpType                    wr_data,
  config_if.master                 cfg_out,
  config_if.slave                  cfg_ret,
  output logic                     rd_valid,
  output fpType                    rd_data,
  output logic                     load_done,
  output logic [CFG_CNT_WIDTH-1:0] word_cnt
);

  localparam logic [CFG_CNT_WIDTH-1:0] LAST_WORD = CFG_CNT_WIDTH'(CHAIN_DEPTH - 1);

  cfg_state_t               state_q, state_d;
  fpType                    data_in_q, data_in_d;
  logic                     data_clk_q, data_clk_d;
  fpType                    rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     load_done_q, load_done_d;
  logic [CFG_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic                     timer_load, timer_expire;

  cfg_phase_timer #(.DIV(DIV)) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (timer_load),
    .expire_o (timer_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      data_in_q   <= '0;
      data_clk_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      load_done_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      data_in_q   <= data_in_d;
      data_clk_q  <= data_clk_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      load_done_q <= load_done_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_in_d   = data_in_q;
    data_clk_d  = data_clk_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    load_done_d = 1'b0;
    word_cnt_d  = word_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (wr_valid) begin
          data_in_d = wr_data;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (timer_expire) begin
          state_d    = CLK_HIGH;
          data_clk_d = 1'b1;
          // Last stage still holds its pre-shift word on this edge.
          rd_data_d  = cfg_ret.data_in;
          rd_valid_d = 1'b1;
        end
      end
      CLK_HIGH: begin
        if (timer_expire) begin
          state_d    = CLK_LOW;
          data_clk_d = 1'b0;
        end
      end
      CLK_LOW: begin
        if (timer_expire) begin
          state_d = IDLE;
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d  = '0;
            load_done_d = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + CFG_CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ready   = (state_q == IDLE);
    timer_load = (state_q == IDLE) ? wr_valid : timer_expire;
  end

  assign cfg_out.data_clk = data_clk_q;
  assign cfg_out.data_in  = data_in_q;
  assign rd_data          = rd_data_q;
  assign rd_valid         = rd_valid_q;
  assign load_done        = load_done_q;
  assign word_cnt         = word_cnt_q;

endmodule

// File: tb/tb_config_chain_master.sv
// Directed bench: three masters (DIV=2/depth 3, DIV=1/depth 3, DIV=1/depth 1)
// each driving a behavioural config chain that shifts on data_clk rising.
module tb_config_chain_master;
  import fp::*;
  import cfg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int n_cmp  = 0;
  int n_fail = 0;

  logic wr_valid_a, wr_ready_a, rd_valid_a, load_done_a;
  logic wr_valid_b, wr_ready_b, rd_valid_b, load_done_b;
  logic wr_valid_c, wr_ready_c, rd_valid_c, load_done_c;
  fpType wr_data_a, rd_data_a, wr_data_b, rd_data_b, wr_data_c, rd_data_c;
  logic [CFG_CNT_WIDTH-1:0] word_cnt_a, word_cnt_b, word_cnt_c;

  config_if out_a ();
  config_if ret_a ();
  config_if out_b ();
  config_if ret_b ();
  config_if out_c ();
  config_if ret_c ();

  config_chain_master #(.CHAIN_DEPTH(3), .DIV(2)) dut_a (
    .clk(clk), .reset(reset), .wr_valid(wr_valid_a), .wr_ready(wr_ready_a),
    .wr_data(wr_data_a), .cfg_out(out_a), .cfg_ret(ret_a), .rd_valid(rd_valid_a),
    .rd_data(rd_data_a), .load_done(load_done_a), .word_cnt(word_cnt_a));

  config_chain_master #(.CHAIN_DEPTH(3), .DIV(1)) dut_b (
    .clk(clk), .reset(reset), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b),
    .wr_data(wr_data_b), .cfg_out(out_b), .cfg_ret(ret_b), .rd_valid(rd_valid_b),
    .rd_data(rd_data_b), .load_done(load_done_b), .word_cnt(word_cnt_b));

  config_chain_master #(.CHAIN_DEPTH(1), .DIV(1)) dut_c (
    .clk(clk), .reset(reset), .wr_valid(wr_valid_c), .wr_ready(wr_ready_c),
    .wr_data(wr_data_c), .cfg_out(out_c), .cfg_ret(ret_c), .rd_valid(rd_valid_c),
    .rd_data(rd_data_c), .load_done(load_done_c), .word_cnt(word_cnt_c));

  // Chain models; contents are not reset, like the real chain.
  fpType ch_a0 = '0, ch_a1 = '0, ch_a2 = '0;
  fpType ch_b0 = '0, ch_b1 = '0, ch_b2 = '0;
  fpType ch_c0 = '0;
  int pulses_a = 0, pulses_b = 0;

  always @(posedge out_a.data_clk) begin
    ch_a0 <= out_a.data_in; ch_a1 <= ch_a0; ch_a2 <= ch_a1;
  end
  always @(posedge out_a.data_clk) pulses_a++;
  always @(posedge out_b.data_clk) begin
    ch_b0 <= out_b.data_in; ch_b1 <= ch_b0; ch_b2 <= ch_b1;
  end
  always @(posedge out_b.data_clk) pulses_b++;
  always @(posedge out_c.data_clk) ch_c0 <= out_c.data_in;

  assign ret_a.data_in = ch_a2;  assign ret_a.data_clk = 1'b0;
  assign ret_b.data_in = ch_b2;  assign ret_b.data_clk = 1'b0;
  assign ret_c.data_in = ch_c0;  assign ret_c.data_clk = 1'b0;

  fpType rdq_a[$];
  int ld_a = 0, ld_c = 0;
  always @(negedge clk) begin
    if (rd_valid_a) rdq_a.push_back(rd_data_a);
    if (load_done_a) ld_a++;
    if (load_done_c) ld_c++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready_a(input string tag);
    int k = 0;
    while (wr_ready_a !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check(tag, {31'd0, wr_ready_a}, 32'd1);
  endtask

  task automatic write_a(input fpType w);
    wait_ready_a($sformatf("a_ready_%h", w));
    wr_data_a  = w;
    wr_valid_a = 1'b1;
    tick();
    wr_valid_a = 1'b0;
    repeat (6) tick();
  endtask

  int    exp_cnt_b [6] = '{1, 2, 0, 1, 2, 0};
  int    p_before;
  int    rd_base;
  int    ld_base;
  fpType w;
  fpType prev;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    wr_valid_a = 1'b0; wr_valid_b = 1'b0; wr_valid_c = 1'b0;
    wr_data_a = '0; wr_data_b = '0; wr_data_c = '0;
    repeat (3) tick();

    check("rst_ready_a",    {31'd0, wr_ready_a}, 1);
    check("rst_dclk_a",     {31'd0, out_a.data_clk}, 0);
    check("rst_din_a",      out_a.data_in, 0);
    check("rst_rdvalid_a",  {31'd0, rd_valid_a}, 0);
    check("rst_rddata_a",   rd_data_a, 0);
    check("rst_ldone_a",    {31'd0, load_done_a}, 0);
    check("rst_wcnt_a",     word_cnt_a, 0);

    reset = 1'b1;
    tick();
    check("deassert_ready_a", {31'd0, wr_ready_a}, 1);

    // Timing: accept 1234 at edge E, rise at E+2, fall at E+4, idle at E+6.
    wr_data_a = 16'h1234; wr_valid_a = 1'b1;
    tick();
    wr_valid_a = 1'b0;
    check("t_din",       out_a.data_in, 16'h1234);
    check("t_busy",      {31'd0, wr_ready_a}, 0);
    check("t_dclk_e0",   {31'd0, out_a.data_clk}, 0);
    tick();
    check("t_dclk_e1",   {31'd0, out_a.data_clk}, 0);
    tick();
    check("t_dclk_e2",   {31'd0, out_a.data_clk}, 1);
    check("t_rdvalid",   {31'd0, rd_valid_a}, 1);
    check("t_rddata",    rd_data_a, 16'h0000);
    tick();
    check("t_dclk_e3",   {31'd0, out_a.data_clk}, 1);
    check("t_rdvalid_1", {31'd0, rd_valid_a}, 0);
    tick();
    check("t_dclk_e4",   {31'd0, out_a.data_clk}, 0);
    tick();
    check("t_ready_e5",  {31'd0, wr_ready_a}, 0);
    tick();
    check("t_ready_e6",  {31'd0, wr_ready_a}, 1);
    check("t_wcnt",      word_cnt_a, 1);
    check("t_din_hold",  out_a.data_in, 16'h1234);
    check("t_pulses",    pulses_a, 1);

    // Busy: DEAD offered during CLK_HIGH must be ignored.
    wr_data_a = 16'h5678; wr_valid_a = 1'b1;
    tick();
    wr_valid_a = 1'b0;
    tick(); tick();
    wr_data_a = 16'hDEAD; wr_valid_a = 1'b1;
    tick();
    check("busy_din_e3",  out_a.data_in, 16'h5678);
    check("busy_dclk_e3", {31'd0, out_a.data_clk}, 1);
    check("busy_ready",   {31'd0, wr_ready_a}, 0);
    tick();
    check("busy_din_e4",  out_a.data_in, 16'h5678);
    wr_valid_a = 1'b0;
    tick(); tick();
    check("busy_idle",    {31'd0, wr_ready_a}, 1);
    check("busy_wcnt",    word_cnt_a, 2);
    tick();
    check("busy_din_end", out_a.data_in, 16'h5678);
    check("busy_pulses",  pulses_a, 2);

    // Reset while data_clk is high.
    wr_data_a = 16'h9999; wr_valid_a = 1'b1;
    tick();
    wr_valid_a = 1'b0;
    tick(); tick();
    check("mid_dclk_hi", {31'd0, out_a.data_clk}, 1);
    p_before = pulses_a;
    reset = 1'b0;
    #1;
    check("mid_dclk_drop", {31'd0, out_a.data_clk}, 0);
    check("mid_wcnt",      word_cnt_a, 0);
    check("mid_din",       out_a.data_in, 0);
    check("mid_ready",     {31'd0, wr_ready_a}, 1);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("mid_ready_post", {31'd0, wr_ready_a}, 1);
    check("mid_dclk_post",  {31'd0, out_a.data_clk}, 0);
    check("mid_no_pulse",   pulses_a, p_before);

    // Readback: two passes through a 3-stage chain.
    rd_base = rdq_a.size();
    ld_base = ld_a;
    write_a(16'h1111);
    write_a(16'h2222);
    write_a(16'h3333);
    check("rb_ldone_pulse", {31'd0, load_done_a}, 1);
    tick();
    check("rb_ldone_once",  ld_a - ld_base, 1);
    check("rb_wcnt_wrap",   word_cnt_a, 0);
    write_a(16'hAAAA);
    write_a(16'hBBBB);
    write_a(16'hCCCC);
    tick();
    check("rb_ldone_twice", ld_a - ld_base, 2);
    check("rb_count",       rdq_a.size() - rd_base, 6);
    if (rdq_a.size() - rd_base == 6) begin
      check("rb_word4", rdq_a[rd_base+3], 16'h1111);
      check("rb_word5", rdq_a[rd_base+4], 16'h2222);
      check("rb_word6", rdq_a[rd_base+5], 16'h3333);
    end

    // Continuous wr_valid, DIV=1: one word every 4 cycles.
    wr_valid_b = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w = 16'hB000 + 16'(k);
      wr_data_b = w;
      check($sformatf("b_accept_ready%0d", k), {31'd0, wr_ready_b}, 1);
      tick();
      check($sformatf("b_din%0d", k),   out_b.data_in, w);
      check($sformatf("b_busy%0d", k),  {31'd0, wr_ready_b}, 0);
      tick();
      check($sformatf("b_dclk_hi%0d", k), {31'd0, out_b.data_clk}, 1);
      tick();
      check($sformatf("b_dclk_lo%0d", k), {31'd0, out_b.data_clk}, 0);
      tick();
      check($sformatf("b_wcnt%0d", k),  word_cnt_b, exp_cnt_b[k]);
      check($sformatf("b_ldone%0d", k), {31'd0, load_done_b}, (exp_cnt_b[k] == 0) ? 1 : 0);
    end
    wr_valid_b = 1'b0;
    tick();
    check("b_pulses", pulses_b, 6);

    // Depth 1: every word completes a pass and reads back the previous one.
    prev = 16'h0000;
    for (int k = 1; k <= 3; k++) begin
      w = 16'h0C00 + 16'(k);
      wr_data_c = w; wr_valid_c = 1'b1;
      tick();
      wr_valid_c = 1'b0;
      check($sformatf("c_din%0d", k), out_c.data_in, w);
      tick();
      check($sformatf("c_rdvalid%0d", k), {31'd0, rd_valid_c}, 1);
      check($sformatf("c_rddata%0d", k),  rd_data_c, prev);
      tick(); tick();
      check($sformatf("c_ldone%0d", k), {31'd0, load_done_c}, 1);
      check($sformatf("c_wcnt%0d", k),  word_cnt_c, 0);
      prev = w;
    end
    tick();
    check("c_ldone_total", ld_c, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
